id_ex_stage_reg: RTL and testbench

// - ID/EX pipeline register between decode (fed by the register file's reg1/reg2 read ports) and execute.
// - Captures operand values, decoded control and register indices on each rising clk edge.
// - Supports hazard freeze (stall), branch flush (bubble) and a saturating bubble counter for perf debug.
// - Register file writes on negedge clk, so operands captured here already reflect same-cycle WB writes.

---
 rtl/id_ex_stage_reg_if.sv | 63 ++++++
 rtl/id_ex_stage_reg.sv | 83 ++++++++
 tb/tb_id_ex_stage_reg.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decoded fields entering the stage plus their registered copies.
interface id_ex_stage_reg_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             flush;
  logic [DW-1:0]    pc_in;
  logic [DW-1:0]    val_rn_in;
  logic [DW-1:0]    val_rm_in;
  logic             imm_in;
  logic [11:0]      shift_op_in;
  logic [23:0]      simm24_in;
  logic [3:0]       dest_in;
  logic [3:0]       src1_in;
  logic [3:0]       src2_in;
  logic [3:0]       exe_cmd_in;
  logic             mem_r_in;
  logic             mem_w_in;
  logic             wb_en_in;
  logic             b_in;
  logic             s_in;
  logic             carry_in;

  logic [DW-1:0]    pc_out;
  logic [DW-1:0]    val_rn_out;
  logic [DW-1:0]    val_rm_out;
  logic             imm_out;
  logic [11:0]      shift_op_out;
  logic [23:0]      simm24_out;
  logic [3:0]       dest_out;
  logic [3:0]       src1_out;
  logic [3:0]       src2_out;
  logic [3:0]       exe_cmd_out;
  logic             mem_r_out;
  logic             mem_w_out;
  logic             wb_en_out;
  logic             b_out;
  logic             s_out;
  logic             carry_out;
  logic             valid_out;
  logic [CNT_W-1:0] bubble_cnt;

  // Decode side: drives the stage inputs, observes the registered copies.
  modport master (
    output freeze, flush, pc_in, val_rn_in, val_rm_in, imm_in, shift_op_in, simm24_in,
           dest_in, src1_in, src2_in, exe_cmd_in, mem_r_in, mem_w_in, wb_en_in, b_in,
           s_in, carry_in,
    input  pc_out, val_rn_out, val_rm_out, imm_out, shift_op_out, simm24_out,
           dest_out, src1_out, src2_out, exe_cmd_out, mem_r_out, mem_w_out, wb_en_out,
           b_out, s_out, carry_out, valid_out, bubble_cnt
  );

  // Pipeline register side.
  modport slave (
    input  freeze, flush, pc_in, val_rn_in, val_rm_in, imm_in, shift_op_in, simm24_in,
           dest_in, src1_in, src2_in, exe_cmd_in, mem_r_in, mem_w_in, wb_en_in, b_in,
           s_in, carry_in,
    output pc_out, val_rn_out, val_rm_out, imm_out, shift_op_out, simm24_out,
           dest_out, src1_out, src2_out, exe_cmd_out, mem_r_out, mem_w_out, wb_en_out,
           b_out, s_out, carry_out, valid_out, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall hold, flush bubble and a saturating bubble counter.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_BUBBLE | EX holds a NOP; all captured fields are zero
//   ST_VALID  | EX holds a real instruction loaded from decode
//
// Flush beats freeze beats load. A flush zeroes every captured field, so
// the control bits are automatically clear whenever the stage is a bubble.
module id_ex_stage_reg #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_reg_if.slave bus
);

  localparam int PW = 3 * DW + 59;

  typedef enum logic [0:0] {
    ST_BUBBLE = 1'b0,
    ST_VALID  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_pipe;
  logic [PW-1:0]    w_pipe_in;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_cnt_sat;

  assign w_pipe_in = {bus.pc_in, bus.val_rn_in, bus.val_rm_in, bus.imm_in, bus.shift_op_in,
                      bus.simm24_in, bus.dest_in, bus.src1_in, bus.src2_in, bus.exe_cmd_in,
                      bus.mem_r_in, bus.mem_w_in, bus.wb_en_in, bus.b_in, bus.s_in,
                      bus.carry_in};

  // Capture decode fields; flush loads all zeros, freeze keeps the current instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_pipe <= '0;
    else if (bus.flush)
      r_pipe <= '0;
    else if (!bus.freeze)
      r_pipe <= w_pipe_in;
  end

  // Valid/bubble state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_BUBBLE;
    else
      r_state <= w_state_nxt;
  end

  // Next state follows the same flush > freeze > load priority as the data.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush)
      w_state_nxt = ST_BUBBLE;
    else if (!bus.freeze)
      w_state_nxt = ST_VALID;
  end

  assign w_cnt_sat = (r_bubble_cnt == {CNT_W{1'b1}});

  // Count every stalled or flushed edge, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_bubble_cnt <= '0;
    else if ((bus.flush || bus.freeze) && !w_cnt_sat)
      r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign {bus.pc_out, bus.val_rn_out, bus.val_rm_out, bus.imm_out, bus.shift_op_out,
          bus.simm24_out, bus.dest_out, bus.src1_out, bus.src2_out, bus.exe_cmd_out,
          bus.mem_r_out, bus.mem_w_out, bus.wb_en_out, bus.b_out, bus.s_out,
          bus.carry_out} = r_pipe;

  assign bus.valid_out  = (r_state == ST_VALID);
  assign bus.bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: a 16-bit-counter instance and a 4-bit-counter
// instance see identical stimulus and are compared every cycle to a model.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] shift_op;
    logic [23:0] simm24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  cmd;
    logic        mem_r;
    logic        mem_w;
    logic        wb_en;
    logic        b;
    logic        s;
    logic        carry;
  } fields_t;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  logic    freeze = 1'b0;
  logic    flush = 1'b0;
  fields_t stim = '0;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: what EX must hold and how many bubbles were inserted.
  fields_t exp_f      = '0;
  logic    exp_valid  = 1'b0;
  int      exp_cnt16  = 0;
  int      exp_cnt4   = 0;

  fields_t act16, act4;

  id_ex_stage_reg_if #(.DW(32), .CNT_W(16)) bus16 ();
  id_ex_stage_reg_if #(.DW(32), .CNT_W(4))  bus4 ();

  assign bus16.freeze = freeze;
  assign bus16.flush  = flush;
  assign bus4.freeze  = freeze;
  assign bus4.flush   = flush;

  assign {bus16.pc_in, bus16.val_rn_in, bus16.val_rm_in, bus16.imm_in, bus16.shift_op_in,
          bus16.simm24_in, bus16.dest_in, bus16.src1_in, bus16.src2_in, bus16.exe_cmd_in,
          bus16.mem_r_in, bus16.mem_w_in, bus16.wb_en_in, bus16.b_in, bus16.s_in,
          bus16.carry_in} = stim;
  assign {bus4.pc_in, bus4.val_rn_in, bus4.val_rm_in, bus4.imm_in, bus4.shift_op_in,
          bus4.simm24_in, bus4.dest_in, bus4.src1_in, bus4.src2_in, bus4.exe_cmd_in,
          bus4.mem_r_in, bus4.mem_w_in, bus4.wb_en_in, bus4.b_in, bus4.s_in,
          bus4.carry_in} = stim;

  assign act16 = {bus16.pc_out, bus16.val_rn_out, bus16.val_rm_out, bus16.imm_out,
                  bus16.shift_op_out, bus16.simm24_out, bus16.dest_out, bus16.src1_out,
                  bus16.src2_out, bus16.exe_cmd_out, bus16.mem_r_out, bus16.mem_w_out,
                  bus16.wb_en_out, bus16.b_out, bus16.s_out, bus16.carry_out};
  assign act4  = {bus4.pc_out, bus4.val_rn_out, bus4.val_rm_out, bus4.imm_out,
                  bus4.shift_op_out, bus4.simm24_out, bus4.dest_out, bus4.src1_out,
                  bus4.src2_out, bus4.exe_cmd_out, bus4.mem_r_out, bus4.mem_w_out,
                  bus4.wb_en_out, bus4.b_out, bus4.s_out, bus4.carry_out};

  id_ex_stage_reg #(.DW(32), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  id_ex_stage_reg #(.DW(32), .CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: EX contents are the last instruction accepted, or nothing after a flush.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_f = '0; exp_valid = 1'b0; exp_cnt16 = 0; exp_cnt4 = 0;
    end else begin
      if (flush) begin
        exp_f = '0; exp_valid = 1'b0;
      end else if (!freeze) begin
        exp_f = stim; exp_valid = 1'b1;
      end
      if (flush || freeze) begin
        exp_cnt16 = (exp_cnt16 + 1 > 65535) ? 65535 : exp_cnt16 + 1;
        exp_cnt4  = (exp_cnt4 + 1 > 15) ? 15 : exp_cnt4 + 1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("cycle16", {act16, bus16.valid_out, bus16.bubble_cnt},
        {exp_f, exp_valid, exp_cnt16[15:0]});
    chk("cycle4", {act4, bus4.valid_out, bus4.bubble_cnt},
        {exp_f, exp_valid, exp_cnt4[3:0]});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_fields", act16, 0);
    chk("reset_valid_cnt", {bus16.valid_out, bus16.bubble_cnt}, 0);
    rst = 1'b1;

    // Load pc=0x40, then assert reset between edges
    stim = '0; stim.pc = 32'h40;
    @(posedge clk); #1;
    chk("pre_reset_pc", bus16.pc_out, 32'h40);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_pc", bus16.pc_out, 0);
    chk("async_reset_valid_cnt", {bus16.valid_out, bus16.bubble_cnt}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Plain load
    stim = '0; stim.rn = 32'h5; stim.rm = 32'hA; stim.wb_en = 1'b1; stim.dest = 4'd3;
    @(negedge clk);
    chk("load_rn", bus16.val_rn_out, 32'h5);
    chk("load_rm", bus16.val_rm_out, 32'hA);
    chk("load_wb_dest_valid", {bus16.wb_en_out, bus16.dest_out, bus16.valid_out}, {1'b1, 4'd3, 1'b1});

    // Freeze 3 cycles with garbage on the inputs
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stim = fields_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      @(negedge clk);
    end
    chk("freeze_hold_rn", bus16.val_rn_out, 32'h5);
    chk("freeze_hold_valid", bus16.valid_out, 1'b1);
    chk("freeze_cnt", bus16.bubble_cnt, 16'd3);
    freeze = 1'b0;

    // Load a store, then flush and freeze together
    stim = '0; stim.pc = 32'h100; stim.mem_w = 1'b1;
    @(negedge clk);
    chk("store_loaded", bus16.mem_w_out, 1'b1);
    flush = 1'b1; freeze = 1'b1;
    stim = fields_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    chk("flush_over_freeze", {bus16.mem_w_out, bus16.valid_out, bus16.bubble_cnt}, {1'b0, 1'b0, 16'd4});
    flush = 1'b0; freeze = 1'b0;

    // Back-to-back: A, flush, B
    stim = '0; stim.pc = 32'hA0; stim.wb_en = 1'b1;
    @(negedge clk);
    chk("b2b_A", {bus16.valid_out, bus16.pc_out}, {1'b1, 32'hA0});
    flush = 1'b1;
    stim.pc = 32'hDEAD;
    @(negedge clk);
    chk("b2b_bubble", {bus16.valid_out, bus16.pc_out, bus16.wb_en_out}, {1'b0, 32'h0, 1'b0});
    flush = 1'b0;
    stim = '0; stim.pc = 32'hB0; stim.s = 1'b1;
    #1;
    chk("b2b_no_comb_path", bus16.pc_out, 32'h0);
    @(negedge clk);
    chk("b2b_B", {bus16.valid_out, bus16.pc_out, bus16.s_out}, {1'b1, 32'hB0, 1'b1});

    // Saturation of the 4-bit counter (count is 5 before this)
    freeze = 1'b1;
    repeat (20) @(negedge clk);
    chk("sat4_after20", bus4.bubble_cnt, 4'd15);
    repeat (2) @(negedge clk);
    chk("sat4_stays", bus4.bubble_cnt, 4'd15);
    chk("cnt16_27", bus16.bubble_cnt, 16'd27);
    freeze = 1'b0;

    // Mixed traffic, checked by the model each cycle
    for (int i = 0; i < 40; i++) begin
      stim   = fields_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      flush  = ($urandom_range(0, 5) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    flush = 1'b0; freeze = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
